// File: rtl/bam_gen_if.sv
// Bus bundle between the MIPS-side register writer and the BAM generator.
//   i_DATA      write data from the ALU
//   i_DUTY_WE   load duty shadow from i_DATA
//   i_PRESC_WE  load tick prescaler from i_DATA
//   i_EN        level run enable
//   o_BAM       serial BAM output (to the GPIO alternate input)
//   o_FRAME     one-cycle pulse in the first clock of every frame
//   o_DUTY      zero-extended duty shadow readback
// master: the register writer; slave: the generator.
interface bam_gen_if;
  logic [31:0] i_DATA;
  logic        i_DUTY_WE;
  logic        i_PRESC_WE;
  logic        i_EN;
  logic        o_BAM;
  logic        o_FRAME;
  logic [31:0] o_DUTY;

  modport master (
    output i_DATA, i_DUTY_WE, i_PRESC_WE, i_EN,
    input  o_BAM, o_FRAME, o_DUTY
  );

  modport slave (
    input  i_DATA, i_DUTY_WE, i_PRESC_WE, i_EN,
    output o_BAM, o_FRAME, o_DUTY
  );
endinterface

// File: rtl/bam_gen.sv
// Bit Angle Modulation generator.
// Emits a binary-weighted, LSB-first BAM waveform: bit k of the active duty
// word is shown for 2^k prescaled ticks, one frame being 2^WIDTH-1 ticks.
// Duty is double-buffered (shadow -> active at frame boundaries) so the
// output never glitches on a duty update.
// Ports:
//   i_clk   system clock, posedge
//   i_arst  asynchronous active-high reset, clears every register
//   bus     bam_gen_if slave: data/write strobes/enable in, BAM/frame/duty out
module bam_gen #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic     i_clk,
  input  logic     i_arst,
  bam_gen_if.slave bus
);

  localparam int unsigned BidxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   active_q, active_d;
  logic [WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [BidxW-1:0]   bidx_q, bidx_d;
  logic               frame_q, frame_d;

  logic               tick;
  logic               last_bit;
  logic [WIDTH-1:0]   wlim;

  // Only the low bits of the data bus are architecturally used.
  logic unused_data;
  assign unused_data = ^bus.i_DATA;

  // A prescaler write restarts the tick period, so it swallows a coincident tick.
  assign tick     = (pcnt_q == presc_q) && !bus.i_PRESC_WE;
  // Bit bidx spans 2^bidx ticks; wcnt runs 0..wlim within it.
  assign wlim     = (WIDTH'(1) << bidx_q) - WIDTH'(1);
  assign last_bit = (bidx_q == BidxW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    wcnt_d   = wcnt_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    bidx_d   = bidx_q;
    frame_d  = 1'b0;

    if (bus.i_DUTY_WE) begin
      shadow_d = bus.i_DATA[WIDTH-1:0];
    end
    if (bus.i_PRESC_WE) begin
      presc_d = bus.i_DATA[PRESC_W-1:0];
      pcnt_d  = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.i_EN) begin
          state_d  = StRun;
          pcnt_d   = '0;
          bidx_d   = '0;
          wcnt_d   = '0;
          active_d = shadow_q;
          frame_d  = 1'b1;
        end
      end
      StRun: begin
        if (!bus.i_EN) begin
          // Counters hold; they are cleared again on the next start.
          state_d = StIdle;
        end else if (!bus.i_PRESC_WE) begin
          if (tick) begin
            pcnt_d = '0;
            if (wcnt_q < wlim) begin
              wcnt_d = wcnt_q + 1'b1;
            end else if (!last_bit) begin
              bidx_d = bidx_q + 1'b1;
              wcnt_d = '0;
            end else begin
              // Frame end: the shadow value from before this edge goes live.
              bidx_d   = '0;
              wcnt_d   = '0;
              active_d = shadow_q;
              frame_d  = 1'b1;
            end
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      active_q <= '0;
      wcnt_q   <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      bidx_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      wcnt_q   <= wcnt_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      bidx_q   <= bidx_d;
      frame_q  <= frame_d;
    end
  end

  // Outputs come straight from registers: no input-to-output path.
  assign bus.o_BAM   = (state_q == StRun) & active_q[bidx_q];
  assign bus.o_FRAME = frame_q;
  assign bus.o_DUTY  = 32'(shadow_q);

endmodule

// File: tb/tb_bam_gen.sv
// Self-checking bench for bam_gen (WIDTH=8, PRESC_W=16).
module tb_bam_gen;

  logic clk;
  logic arst;

  bam_gen_if bus ();

  bam_gen #(
    .WIDTH  (8),
    .PRESC_W(16)
  ) dut (
    .i_clk (clk),
    .i_arst(arst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: frame position held as a tick index t (0..254) and
  // clocks elapsed inside the current tick; the bit on show is the k with
  // 2^k-1 <= t < 2^(k+1)-1, since bit k lasts 2^k ticks.
  bit          m_run;
  bit          m_frame;
  int          m_t;
  int          m_pd;
  logic [7:0]  m_active;
  logic [7:0]  m_shadow;
  logic [15:0] m_presc;

  function automatic int bit_of(int t);
    int k;
    k = 0;
    while (((1 << (k + 1)) - 1) <= t) k++;
    return k;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_frame = 0; m_t = 0; m_pd = 0;
    m_active = '0; m_shadow = '0; m_presc = '0;
  endtask

  task automatic model_edge();
    logic [7:0]  sh;
    logic [15:0] pr;
    sh = m_shadow;
    pr = m_presc;
    m_frame = 0;
    if (!m_run) begin
      if (bus.i_EN) begin
        m_run = 1; m_t = 0; m_pd = 0; m_active = sh; m_frame = 1;
      end
    end else if (!bus.i_EN) begin
      m_run = 0;
    end else if (!bus.i_PRESC_WE) begin
      if (m_pd == int'(pr)) begin
        m_pd = 0;
        if (m_t == 254) begin
          m_t = 0; m_active = sh; m_frame = 1;
        end else begin
          m_t++;
        end
      end else begin
        m_pd++;
      end
    end
    if (bus.i_PRESC_WE) begin
      m_presc = bus.i_DATA[15:0];
      m_pd    = 0;
    end
    if (bus.i_DUTY_WE) m_shadow = bus.i_DATA[7:0];
  endtask

  // One clock: advance the model on the edge, compare outputs 1 unit later.
  task automatic cyc();
    logic exp_bam;
    @(posedge clk);
    model_edge();
    #1;
    exp_bam = m_run && m_active[bit_of(m_t)];
    check("bam", 32'(bus.o_BAM), 32'(exp_bam));
    check("frame", 32'(bus.o_FRAME), 32'(m_frame));
    check("duty_rb", bus.o_DUTY, {24'd0, m_shadow});
  endtask

  task automatic do_reset();
    arst = 1'b1;
    #1;
    model_reset();
    check("rst_bam", 32'(bus.o_BAM), 32'd0);
    check("rst_frame", 32'(bus.o_FRAME), 32'd0);
    check("rst_duty", bus.o_DUTY, 32'd0);
    arst = 1'b0;
    bus.i_EN = 1'b0; bus.i_DUTY_WE = 1'b0; bus.i_PRESC_WE = 1'b0; bus.i_DATA = '0;
    cyc();
  endtask

  task automatic write_duty(logic [31:0] d);
    bus.i_DATA = d; bus.i_DUTY_WE = 1'b1;
    cyc();
    bus.i_DUTY_WE = 1'b0;
    check("duty_write", bus.o_DUTY, {24'd0, d[7:0]});
  endtask

  task automatic write_presc(logic [31:0] p);
    bus.i_DATA = p; bus.i_PRESC_WE = 1'b1;
    cyc();
    bus.i_PRESC_WE = 1'b0;
  endtask

  // Count from the current cycle up to (not including) the next o_FRAME cycle.
  task automatic measure(output int hi, output int len, output int first);
    hi = 0; len = 0; first = -1;
    do begin
      if (bus.o_BAM) begin
        if (first < 0) first = len;
        hi++;
      end
      len++;
      cyc();
    end while (!bus.o_FRAME && len < 5000);
  endtask

  typedef struct {
    logic [7:0]  duty;
    logic [15:0] presc;
    int          hi;
    int          len;
    int          first;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, len, first;

    vecs[0] = '{duty: 8'h01, presc: 16'd0, hi: 1,   len: 255,  first: 0};
    vecs[1] = '{duty: 8'h80, presc: 16'd0, hi: 128, len: 255,  first: 127};
    vecs[2] = '{duty: 8'hFF, presc: 16'd3, hi: 1020, len: 1020, first: 0};
    vecs[3] = '{duty: 8'h00, presc: 16'd1, hi: 0,   len: 510,  first: -1};
    vecs[4] = '{duty: 8'hA5, presc: 16'd2, hi: 495, len: 765,  first: 0};
    vecs[5] = '{duty: 8'h55, presc: 16'd0, hi: 85,  len: 255,  first: 0};

    arst = 1'b1;
    bus.i_EN = 1'b0; bus.i_DUTY_WE = 1'b0; bus.i_PRESC_WE = 1'b0; bus.i_DATA = '0;
    do_reset();

    // Table: one full frame per duty/prescaler pair.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      write_presc(32'(vecs[i].presc));
      write_duty(32'(vecs[i].duty));
      bus.i_EN = 1'b1;
      cyc();
      check("start_frame", 32'(bus.o_FRAME), 32'd1);
      measure(hi, len, first);
      check("vec_high", 32'(hi), 32'(vecs[i].hi));
      check("vec_len", 32'(len), 32'(vecs[i].len));
      check("vec_first", 32'(first), 32'(vecs[i].first));
    end

    // Reset while running: outputs drop at once and the block stays idle.
    do_reset();
    repeat (20) cyc();

    // Duty change 0xFF -> 0x00 applies from the following frame.
    do_reset();
    write_presc(32'd3);
    write_duty(32'hFF);
    bus.i_EN = 1'b1;
    cyc();
    measure(hi, len, first);
    check("ff_high", 32'(hi), 32'd1020);
    write_duty(32'h00);
    measure(hi, len, first);
    check("ff_rest_high", 32'(hi), 32'd1019);
    measure(hi, len, first);
    check("zero_high", 32'(hi), 32'd0);
    check("zero_len", 32'(len), 32'd1020);

    // Mid-frame write at cycle 100, then a write on the frame-end edge.
    do_reset();
    write_duty(32'h01);
    bus.i_EN = 1'b1;
    cyc();
    repeat (100) cyc();
    write_duty(32'hFE);
    measure(hi, len, first);
    check("midw_rest_high", 32'(hi), 32'd0);
    check("midw_rest_len", 32'(len), 32'd154);
    measure(hi, len, first);
    check("fe_high", 32'(hi), 32'd254);
    check("fe_first", 32'(first), 32'd1);
    repeat (254) cyc();
    bus.i_DATA = 32'h01; bus.i_DUTY_WE = 1'b1;
    cyc();
    bus.i_DUTY_WE = 1'b0;
    check("edge_w_frame", 32'(bus.o_FRAME), 32'd1);
    measure(hi, len, first);
    check("edge_w_old", 32'(hi), 32'd254);
    measure(hi, len, first);
    check("edge_w_new", 32'(hi), 32'd1);

    // Disable at cycle 50 and restart from bit 0.
    do_reset();
    write_duty(32'hA5);
    bus.i_EN = 1'b1;
    cyc();
    repeat (50) cyc();
    bus.i_EN = 1'b0;
    cyc();
    check("dis_bam", 32'(bus.o_BAM), 32'd0);
    repeat (5) cyc();
    bus.i_EN = 1'b1;
    cyc();
    check("re_frame", 32'(bus.o_FRAME), 32'd1);
    check("re_bit0", 32'(bus.o_BAM), 32'd1);
    measure(hi, len, first);
    check("re_high", 32'(hi), 32'd165);
    check("re_len", 32'(len), 32'd255);

    // Prescaler rewrite mid-bit only restarts the tick period.
    do_reset();
    write_presc(32'd3);
    write_duty(32'hA5);
    bus.i_EN = 1'b1;
    cyc();
    repeat (10) cyc();
    write_presc(32'd3);
    measure(hi, len, first);
    check("pw_rest_len", 32'(len), 32'd1012);
    check("pw_rest_high", 32'(hi), 32'd656);

    // Simultaneous duty and prescaler write from one data word.
    do_reset();
    bus.i_DATA = 32'h3; bus.i_DUTY_WE = 1'b1; bus.i_PRESC_WE = 1'b1;
    cyc();
    bus.i_DUTY_WE = 1'b0; bus.i_PRESC_WE = 1'b0;
    check("both_duty", bus.o_DUTY, 32'd3);
    bus.i_EN = 1'b1;
    cyc();
    measure(hi, len, first);
    check("both_high", 32'(hi), 32'd12);
    check("both_len", 32'(len), 32'd1020);

    // Random traffic against the model.
    do_reset();
    bus.i_EN = 1'b1;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 2999) == 0) begin
        do_reset();
        bus.i_EN = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) bus.i_EN = ~bus.i_EN;
      bus.i_PRESC_WE = ($urandom_range(0, 399) == 0);
      bus.i_DUTY_WE  = ($urandom_range(0, 49) == 0);
      if (bus.i_PRESC_WE) bus.i_DATA = ($urandom() & 32'hFFFF_0000) | $urandom_range(0, 3);
      else                bus.i_DATA = $urandom();
      cyc();
    end
    bus.i_DUTY_WE = 1'b0; bus.i_PRESC_WE = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
